// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one SRAM-like memory port between the fetch and data requesters, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed data-over-inst priority.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok,

  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t      state, state_nx;
  owner_t      owner, owner_nx;
  owner_t      last,  last_nx;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        grant_inst;
  logic        grant_data;
  logic        in_data;

  // Grants are only ever issued from IDLE; contention policy is the build option.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == S_IDLE) begin
      if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last == OWN_DATA) begin
          grant_inst = 1'b1;
        end else begin
          grant_data = 1'b1;
        end
`else
        grant_data = 1'b1;
`endif
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    case (state)
      S_IDLE: begin
        if (grant_data) begin
          owner_nx = OWN_DATA;
          last_nx  = OWN_DATA;
          state_nx = S_ADDR;
        end else if (grant_inst) begin
          owner_nx = OWN_INST;
          last_nx  = OWN_INST;
          state_nx = S_ADDR;
        end
      end
      S_ADDR: begin
        // A same-cycle mem_data_ok is deliberately ignored here.
        if (mem_addr_ok) begin
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_data_ok) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      owner <= OWN_INST;
      last  <= OWN_DATA;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_data) begin
      wr_q    <= data_wr;
      size_q  <= data_size;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
    end else if (grant_inst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd2;
      addr_q  <= inst_addr;
      wdata_q <= '0;
    end
  end

  assign in_data = (state == S_DATA);

  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;

    mem_req   = (state == S_ADDR);
    mem_wr    = wr_q;
    mem_size  = size_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;

    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    if (in_data) begin
      if (owner == OWN_INST) begin
        inst_data_ok = mem_data_ok;
        inst_rdata   = mem_rdata;
      end else begin
        data_data_ok = mem_data_ok;
        data_rdata   = mem_rdata;
      end
    end

    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Checks mem_port_arbiter against a transaction-level model: directed scenarios, then random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata),
    .mem_data_ok(mem_data_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, recorded when granted.
  bit          m_active;
  bit          m_addr_done;
  bit          m_own_data;
  bit          m_last_data;
  bit          m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_done_inst;
  int          m_done_data;

  always @(negedge clk) begin
    bit g_data, g_inst, e_req, e_iok, e_dok;
    logic [31:0] e_ird, e_drd;
    if (reset) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_busy", busy, 0);
      check("rst_inst_data_ok", inst_data_ok, 0);
      check("rst_data_data_ok", data_data_ok, 0);
      m_active    = 0;
      m_addr_done = 0;
      m_last_data = 1;
    end else begin
      g_data = 0; g_inst = 0; e_iok = 0; e_dok = 0; e_ird = '0; e_drd = '0;
      if (!m_active) begin
`ifdef ARB_ROUND_ROBIN_EN
        g_data = data_req && (!inst_req || !m_last_data);
`else
        g_data = data_req;
`endif
        g_inst = inst_req && !g_data;
      end
      e_req = m_active && !m_addr_done;
      if (m_active && m_addr_done) begin
        if (m_own_data) begin
          e_dok = mem_data_ok;
          e_drd = mem_rdata;
        end else begin
          e_iok = mem_data_ok;
          e_ird = mem_rdata;
        end
      end
      check("inst_addr_ok", inst_addr_ok, g_inst);
      check("data_addr_ok", data_addr_ok, g_data);
      check("mem_req", mem_req, e_req);
      check("busy", busy, m_active);
      check("inst_data_ok", inst_data_ok, e_iok);
      check("data_data_ok", data_data_ok, e_dok);
      check("inst_rdata", inst_rdata, e_ird);
      check("data_rdata", data_rdata, e_drd);
      if (e_req) begin
        check("mem_wr", mem_wr, m_wr);
        check("mem_size", mem_size, m_size);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
      end
      if (g_data || g_inst) begin
        m_active    = 1;
        m_addr_done = 0;
        m_own_data  = g_data;
        m_last_data = g_data;
        m_wr        = g_data ? data_wr : 1'b0;
        m_size      = g_data ? data_size : 2'd2;
        m_addr      = g_data ? data_addr : inst_addr;
        m_wdata     = g_data ? data_wdata : 32'h0;
      end else if (m_active && !m_addr_done) begin
        if (mem_addr_ok) m_addr_done = 1;
      end else if (m_active && mem_data_ok) begin
        m_active = 0;
        if (m_own_data) m_done_data++;
        else            m_done_inst++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cnt, busy_cnt, dok_cnt;
    bit ia, da;

    reset = 1'b1;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_rdata = '0; mem_data_ok = 0;
    sample();
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_size", mem_size, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_inst_rdata", inst_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    step();
    reset = 1'b0;

    // Zero-wait fetch
    step(); inst_req = 1; inst_addr = 32'hbfc00000;
    sample(); check("zw_accept", inst_addr_ok, 1);
    step(); inst_req = 0; mem_addr_ok = 1;
    sample(); check("zw_mem_req", mem_req, 1); check("zw_mem_addr", mem_addr, 32'hbfc00000);
    check("zw_mem_size", mem_size, 2); check("zw_mem_wr", mem_wr, 0);
    step(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3c1d0001;
    sample(); check("zw_inst_data_ok", inst_data_ok, 1); check("zw_inst_rdata", inst_rdata, 32'h3c1d0001);
    check("zw_data_data_ok", data_data_ok, 0);
    step(); mem_data_ok = 0; mem_rdata = '0;
    sample(); check("zw_idle_busy", busy, 0);

    // Simultaneous requests: data store wins, inst follows
    step(); inst_req = 1; inst_addr = 32'hbfc00004;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80001000; data_wdata = 32'hdeadbeef;
    sample(); check("sim_data_grant", data_addr_ok, 1); check("sim_inst_wait", inst_addr_ok, 0);
    step(); data_req = 0; mem_addr_ok = 1;
    sample(); check("sim_mem_wr", mem_wr, 1); check("sim_mem_wdata", mem_wdata, 32'hdeadbeef);
    check("sim_inst_wait2", inst_addr_ok, 0);
    step(); mem_addr_ok = 0; mem_data_ok = 1;
    sample(); check("sim_data_data_ok", data_data_ok, 1);
    step(); mem_data_ok = 0;
    sample(); check("sim_inst_grant", inst_addr_ok, 1);
    step(); inst_req = 0; mem_addr_ok = 1;
    sample(); check("sim_inst_addr", mem_addr, 32'hbfc00004);
    step(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h00000020;
    sample(); check("sim_inst_data_ok", inst_data_ok, 1);
    step(); mem_data_ok = 0; mem_rdata = '0;

    // Wait states on a half-word load
    step(); data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h80002002;
    sample(); check("ws_accept", data_addr_ok, 1);
    req_cnt = 0; busy_cnt = 0; dok_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      data_req    = 0;
      mem_addr_ok = (c == 4);
      mem_data_ok = (c == 8);
      mem_rdata   = (c == 8) ? 32'h1234abcd : 32'h0;
      sample();
      if (mem_req) req_cnt++;
      if (busy) busy_cnt++;
      if (data_data_ok) dok_cnt++;
    end
    check("ws_mem_req_cycles", req_cnt, 4);
    check("ws_busy_cycles", busy_cnt, 8);
    check("ws_data_ok_pulses", dok_cnt, 1);

    // Spurious memory handshakes while idle
    step(); mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hffffffff;
    sample(); check("sp_inst_data_ok", inst_data_ok, 0); check("sp_data_data_ok", data_data_ok, 0);
    check("sp_busy", busy, 0);
    step(); mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    sample(); check("sp_still_idle", busy, 0);

    // Reset in the middle of an address phase
    step(); inst_req = 1; inst_addr = 32'hbfc00000;
    sample(); check("rm_accept", inst_addr_ok, 1);
    step(); inst_req = 0;
    sample(); check("rm_mem_req", mem_req, 1);
    #2; reset = 1'b1;
    #1; check("rm_async_mem_req", mem_req, 0); check("rm_async_busy", busy, 0);
    step(); step();
    reset = 1'b0;
    dok_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step(); mem_addr_ok = 1; mem_data_ok = 1;
      sample(); if (inst_data_ok) dok_cnt++;
    end
    check("rm_no_completion", dok_cnt, 0);
    step(); mem_addr_ok = 0; mem_data_ok = 0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ia = inst_addr_ok;
      da = data_addr_ok;
      @(posedge clk);
      #1;
      if (!inst_req || ia) begin
        inst_req  = ($urandom % 3 == 0);
        inst_addr = $urandom & 32'hfffffffc;
      end else if ($urandom % 16 == 0) begin
        inst_req = 0;
      end
      if (!data_req || da) begin
        data_req   = ($urandom % 3 == 0);
        data_wr    = $urandom % 2;
        data_size  = 2'($urandom % 3);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end else if ($urandom % 16 == 0) begin
        data_req = 0;
      end
      mem_addr_ok = ($urandom % 3 == 0);
      mem_data_ok = ($urandom % 3 == 0);
      mem_rdata   = $urandom;
    end
    check("rand_progress", 32'((m_done_inst > 2) && (m_done_data > 2)), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's instruction-fetch and data (MEM-stage) requesters onto one shared SRAM-like memory port with req/addr_ok/data_ok handshakes. Sits between the pipeline front end and the memory stage on one side and the single external memory port on the other. Keeps at most one transaction outstanding on the shared port. Exposes `busy` so hazard logic can stall the pipeline.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req`  in  1  fetch request; held until `inst_addr_ok`.
- `inst_addr`  in  32  fetch address; reads only, 4-byte size.
- `inst_addr_ok`  out  1  one-cycle pulse: fetch request accepted.
- `inst_rdata`  out  32  fetch read data; valid with `inst_data_ok`.
- `inst_data_ok`  out  1  one-cycle pulse: fetch completed.
- `data_req`  in  1  data request; held until `data_addr_ok`.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  32  data address.
- `data_wdata`  in  32  store data.
- `data_addr_ok`  out  1  one-cycle pulse: data request accepted.
- `data_rdata`  out  32  load data; valid with `data_data_ok`.
- `data_data_ok`  out  1  one-cycle pulse: load or store completed.
- `mem_req`  out  1  shared-port request.
- `mem_wr`  out  1  shared-port write flag.
- `mem_size`  out  2  shared-port access size.
- `mem_addr`  out  32  shared-port address.
- `mem_wdata`  out  32  shared-port write data.
- `mem_addr_ok`  in  1  memory accepted the address phase.
- `mem_rdata`  in  32  memory read data.
- `mem_data_ok`  in  1  memory completed the transaction.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `owner` (INST/DATA), `last` (last granted owner), and latched `wr`, `size`, `addr`, `wdata`.
- **IDLE, grant:**
  - Grant goes to a requester with its `*_req` high.
  - Combinationally pulse that requester's `*_addr_ok`.
  - Latch its fields; for inst, `wr` = 0 and `size` = 2.
  - Set `owner`; go to ADDR.
  - Default priority: data over inst.
- **ADDR:**
  - `mem_req` = 1; `mem_*` outputs driven from the latched registers.
  - On `mem_addr_ok`, go to DATA.
- **DATA:**
  - `mem_req` = 0.
  - On `mem_data_ok`, combinationally pulse the owner's `*_data_ok` in the same cycle, then go to IDLE.
- **Read-data routing:**
  - The owner's `*_rdata` = `mem_rdata` while in DATA.
  - Both `*_rdata` = 0 at all other times.
- **Non-owner isolation:**
  - No `*_addr_ok` outside IDLE; new requests wait.
  - The non-owner's `*_data_ok` and `*_rdata` are never driven.
- **Spurious inputs:** `mem_addr_ok` outside ADDR and `mem_data_ok` outside DATA are ignored.
- **Address-phase hold:** `mem_addr_ok` and `mem_data_ok` in the same ADDR cycle: only the address phase is taken; completion is expected in a later cycle.
- **Requester withdrawal:** a requester dropping `*_req` before acceptance is legal; nothing is granted.

## Timing
- **Reset values:**
  - State = IDLE, `owner` = INST, `last` = DATA.
  - All latched registers = 0.
  - Therefore every output = 0: `mem_req`, `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`, all `*_addr_ok`, `*_data_ok`, `*_rdata`, and `busy`.
- **Reset mid-transaction:** the transaction is dropped and `mem_req` falls asynchronously. No completion pulse is ever issued for the dropped transaction.
- **Latency:**
  - Accept in cycle 0.
  - `mem_req` asserted from cycle 1.
  - With zero-wait memory (`mem_addr_ok` in cycle 1, `mem_data_ok` in cycle 2): `*_data_ok` in cycle 2, next accept in cycle 3.
- **Throughput:** one transaction per ≥3 cycles.
- **`busy`:** high from the cycle after acceptance through the `mem_data_ok` cycle.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- **Defined:** when both requests are high in IDLE, grant the requester ≠ `last`. `last` updates on every grant.
- **Undefined:** fixed data-over-inst priority; `last` is still maintained but unused.
- **Either setting:** a single requester is always granted immediately.

## Test plan
- **Reset:** `reset` = 1 mid-ADDR with `inst_addr` = 0xbfc00000 → `mem_req` = 0 asynchronously, `busy` = 0, and no `inst_data_ok` after release.
- **Zero-wait fetch:** `inst_req` with addr 0xbfc00000, `mem_addr_ok` in cycle 1, `mem_data_ok` + `mem_rdata` = 0x3c1d0001 in cycle 2 → `inst_data_ok` = 1 and `inst_rdata` = 0x3c1d0001 in cycle 2; `data_data_ok` = 0.
- **Simultaneous requests, macro off:** `inst_req` and `data_req` together (store, size 2, addr 0x80001000, wdata 0xdeadbeef) → data granted first, `mem_wr` = 1, `mem_wdata` = 0xdeadbeef; inst is granted in IDLE after `data_data_ok`.
- **Round robin, `ARB_ROUND_ROBIN_EN` defined:** both requests held continuously → grants alternate DATA, INST, DATA, INST.
- **Wait states:** `mem_addr_ok` delayed 3 cycles, then `mem_data_ok` delayed 4 cycles → `mem_req` high exactly 4 cycles, `busy` high 8 cycles, single `data_data_ok` pulse.
- **Spurious completion:** `mem_data_ok` pulsed in IDLE → no `*_data_ok` output and state stays IDLE.
